// File: rtl/regfile_rename_ckpt_pkg.sv
// Shared sizing, rename-entry types and the commit tag-clear helper for the
// rename register file and its checkpoint bank.
package regfile_rename_ckpt_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int RA_W  = 5;
  localparam int ROB_W = 4;
  localparam int NRD   = 2;
  localparam int NCKPT = 4;
  localparam int CK_W  = 2;

  typedef struct packed {
    logic             busy;
    logic [ROB_W-1:0] tag;
  } ren_t;

  typedef ren_t [NREG-1:0] ren_tbl_t;

  // A commit only retires the rename if the entry still points at that ROB tag.
  function automatic ren_tbl_t commit_clear(input ren_tbl_t tbl, input logic en,
                                            input logic [RA_W-1:0] rd,
                                            input logic [ROB_W-1:0] tag);
    ren_tbl_t res;
    res          = tbl;
    res[rd].busy = tbl[rd].busy & ~(en & (tbl[rd].tag == tag));
    return res;
  endfunction

endpackage

// File: rtl/regfile_rename_ckpt_bank.sv
// In-order ring of rename-table snapshots. Slots track commits so a restore
// never resurrects a busy bit that has already retired.
module regfile_rename_ckpt_bank
  import regfile_rename_ckpt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy_i,
  input  logic             clr_i,
  input  logic             cm_en_i,
  input  logic [RA_W-1:0]  cm_rd_i,
  input  logic [ROB_W-1:0] cm_tag_i,
  input  logic             save_i,
  input  ren_tbl_t         snap_i,
  input  logic             free_i,
  input  logic             restore_i,
  input  logic [CK_W-1:0]  rid_i,
  output ren_tbl_t         rest_tbl_o,
  output logic [CK_W-1:0]  tail_o,
  output logic             full_o
);

  localparam logic [CK_W:0] CNT_MAX = (CK_W+1)'(NCKPT);

  ren_tbl_t        slot_q [NCKPT];
  logic [CK_W-1:0] head_q, tail_q;
  logic [CK_W:0]   cnt_q;
  logic            full, save_ok, free_ok;
  logic [CK_W-1:0] span;
  logic [CK_W:0]   keep;

  assign full       = (cnt_q == CNT_MAX);
  assign save_ok    = save_i & ~restore_i & ~full;
  assign free_ok    = free_i & (cnt_q != '0);
  // Restored slot stays live; a zero span means the whole ring is kept.
  assign span       = rid_i - head_q + CK_W'(1);
  assign keep       = (span == '0) ? CNT_MAX : {1'b0, span};
  assign rest_tbl_o = commit_clear(slot_q[rid_i], cm_en_i, cm_rd_i, cm_tag_i);
  assign tail_o     = tail_q;
  assign full_o     = full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (rdy_i && restore_i) begin
      tail_q <= rid_i + CK_W'(1);
      head_q <= head_q + CK_W'(free_ok);
      cnt_q  <= keep - (CK_W+1)'(free_ok);
    end else if (rdy_i) begin
      tail_q <= tail_q + CK_W'(save_ok);
      head_q <= head_q + CK_W'(free_ok);
      cnt_q  <= cnt_q + (CK_W+1)'(save_ok) - (CK_W+1)'(free_ok);
    end
  end

  // Snapshot contents are don't-care until saved, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rdy_i && !clr_i) begin
      for (int s = 0; s < NCKPT; s++) begin
        slot_q[s] <= (save_ok && (tail_q == CK_W'(s))) ? snap_i
                   : commit_clear(slot_q[s], cm_en_i, cm_rd_i, cm_tag_i);
      end
    end
  end

endmodule

// File: rtl/regfile_rename_ckpt.sv
// Architectural register file with busy/tag rename state, commit bypass on the
// dispatch read ports, and single-cycle checkpoint restore on mispredict.
module regfile_rename_ckpt
  import regfile_rename_ckpt_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy_i,
  input  logic                clr_i,
  input  logic [NRD-1:0]      rd_en_i,
  input  logic [NRD*RA_W-1:0] rd_addr_i,
  output logic [NRD-1:0]      rd_valid_o,
  output logic [NRD-1:0]      rd_ready_o,
  output logic [NRD*XLEN-1:0] rd_val_o,
  input  logic                ds_en_i,
  input  logic [RA_W-1:0]     ds_rd_i,
  input  logic [ROB_W-1:0]    ds_tag_i,
  input  logic                cm_en_i,
  input  logic [RA_W-1:0]     cm_rd_i,
  input  logic [ROB_W-1:0]    cm_tag_i,
  input  logic [XLEN-1:0]     cm_val_i,
  input  logic                ck_save_i,
  output logic [CK_W-1:0]     ck_id_o,
  output logic                ck_full_o,
  input  logic                ck_free_i,
  input  logic                ck_restore_i,
  input  logic [CK_W-1:0]     ck_rid_i
);

  logic [XLEN-1:0] v_q [NREG];
  ren_tbl_t        tbl_q, tbl_d, rest_tbl;
  logic [RA_W-1:0] ra;
  ren_t            ent;
  logic            ds_ok;

  regfile_rename_ckpt_bank u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy_i      (rdy_i),
    .clr_i      (clr_i),
    .cm_en_i    (cm_en_i),
    .cm_rd_i    (cm_rd_i),
    .cm_tag_i   (cm_tag_i),
    .save_i     (ck_save_i),
    .snap_i     (tbl_d),
    .free_i     (ck_free_i),
    .restore_i  (ck_restore_i),
    .rid_i      (ck_rid_i),
    .rest_tbl_o (rest_tbl),
    .tail_o     (ck_id_o),
    .full_o     (ck_full_o)
  );

  assign ds_ok = ds_en_i & (ds_rd_i != '0);

  // Normal-path next table: commit clear first, then dispatch overrides it.
  always_comb begin
    tbl_d          = commit_clear(tbl_q, cm_en_i, cm_rd_i, cm_tag_i);
    tbl_d[ds_rd_i] = ds_ok ? ren_t'{busy: 1'b1, tag: ds_tag_i} : tbl_d[ds_rd_i];
  end

  // Source lookups see only pre-edge state, plus the live commit bus.
  always_comb begin
    rd_valid_o = rd_en_i;
    rd_ready_o = '0;
    rd_val_o   = '0;
    ra         = '0;
    ent        = '0;
    for (int k = 0; k < NRD; k++) begin
      ra  = rd_addr_i[k*RA_W +: RA_W];
      ent = tbl_q[ra];
      if (!rd_en_i[k]) begin
        rd_ready_o[k]              = 1'b0;
        rd_val_o[k*XLEN +: XLEN]   = '0;
      end else if (!ent.busy) begin
        rd_ready_o[k]              = 1'b1;
        rd_val_o[k*XLEN +: XLEN]   = v_q[ra];
      end else if (cm_en_i && (cm_tag_i == ent.tag)) begin
        rd_ready_o[k]              = 1'b1;
        rd_val_o[k*XLEN +: XLEN]   = cm_val_i;
      end else begin
        rd_ready_o[k]              = 1'b0;
        rd_val_o[k*XLEN +: XLEN]   = XLEN'(ent.tag);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) v_q[r] <= '0;
    end else if (cm_en_i && (cm_rd_i != '0)) begin
      v_q[cm_rd_i] <= cm_val_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q <= '0;
    end else if (clr_i) begin
      for (int r = 0; r < NREG; r++) tbl_q[r].busy <= 1'b0;
    end else if (rdy_i) begin
      tbl_q <= ck_restore_i ? rest_tbl : tbl_d;
    end
  end

endmodule
